// File: rtl/id_ex_stage_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register: control-bundle bit
// positions, stall FSM states and the bubble constants.
package pipe_pkg;

  // Control bundle layout {ALUOp[1:0],RegDst,ALUSrc,Branch,MemRead,MemWrite,MemToReg,RegWrite}
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_BRANCH   = 4;
  localparam int CTRL_ALUSRC   = 5;
  localparam int CTRL_REGDST   = 6;
  localparam int CTRL_ALUOP    = 7;
  localparam int CTRL_BITS     = 9;

  // A bubble carries no side effects: every control bit low.
  localparam logic [CTRL_BITS-1:0] BUBBLE_CTRL = '0;

  // Saturation ceiling of the bubble counter.
  localparam logic [15:0] BCNT_MAX = 16'hFFFF;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// Decode-side to EX-side bundle of the ID/EX register.
//
// Handshake: the decode side presents an instruction with in_valid=1. It is
// accepted on an enabled clock edge where stall_if=0 and flush=0; while
// stall_if=1 the decode side must hold every in_* field unchanged. out_valid
// marks a real instruction in EX; out_* fields are all zero otherwise.
interface id_ex_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 10,
  parameter int RA_W   = 5,
  parameter int CTRL_W = 9,
  parameter int IMM_W  = 16
);
  logic              in_valid;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_rega;
  logic [DATA_W-1:0] in_regb;
  logic [IMM_W-1:0]  in_imm;
  logic              in_imm_zext;
  logic [RA_W-1:0]   in_rs;
  logic [RA_W-1:0]   in_rt;
  logic [RA_W-1:0]   in_rd;
  logic [PC_W-1:0]   in_pc;

  logic              stall_if;
  logic              out_valid;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_rega;
  logic [DATA_W-1:0] out_regb;
  logic [DATA_W-1:0] out_imm;
  logic [RA_W-1:0]   out_rs;
  logic [RA_W-1:0]   out_rt;
  logic [RA_W-1:0]   out_rd;
  logic [PC_W-1:0]   out_pc;
  logic [15:0]       bubble_count;

  modport master (
    output in_valid, in_ctrl, in_rega, in_regb, in_imm, in_imm_zext,
           in_rs, in_rt, in_rd, in_pc,
    input  stall_if, out_valid, out_ctrl, out_rega, out_regb, out_imm,
           out_rs, out_rt, out_rd, out_pc, bubble_count
  );

  modport slave (
    input  in_valid, in_ctrl, in_rega, in_regb, in_imm, in_imm_zext,
           in_rs, in_rt, in_rd, in_pc,
    output stall_if, out_valid, out_ctrl, out_rega, out_regb, out_imm,
           out_rs, out_rt, out_rd, out_pc, bubble_count
  );
endinterface

// File: rtl/id_ex_stage_reg_hazard.sv
// Load-use comparator: the instruction in EX is a load whose target register
// is read by the instruction currently in decode.
module hazard_detect_unit #(
  parameter int RA_W = 5
) (
  input  logic            ex_valid,
  input  logic            ex_memread,
  input  logic [RA_W-1:0] ex_rt,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  output logic            hazard
);
  // Register 0 is hard-wired, so a load into it never creates a dependency.
  assign hazard = ex_valid & ex_memread & (ex_rt != '0) & id_valid
                & ((ex_rt == id_rs) | (ex_rt == id_rt));
endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with flush, load-use stall FSM, immediate
// extension and a saturating count of inserted hazard bubbles.
module id_ex_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 10,
  parameter int RA_W      = 5,
  parameter int CTRL_W    = 9,
  parameter int IMM_W     = 16,
  parameter int STALL_CYC = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clkEnable,
  input  logic             flush,
  id_ex_stage_reg_if.slave bus,
  output state_t           fsm_state
);

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] rega_q, regb_q, imm_q;
  logic [RA_W-1:0]   rs_q, rt_q, rd_q;
  logic [PC_W-1:0]   pc_q;
  logic [15:0]       bcnt_q;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              hazard, take, bump, stall;
  logic [DATA_W-1:0] imm_ext;

  hazard_detect_unit #(.RA_W(RA_W)) u_hazard (
    .ex_valid   (valid_q),
    .ex_memread (ctrl_q[CTRL_MEMREAD]),
    .ex_rt      (rt_q),
    .id_valid   (bus.in_valid),
    .id_rs      (bus.in_rs),
    .id_rt      (bus.in_rt),
    .hazard     (hazard)
  );

  assign imm_ext = bus.in_imm_zext
                 ? {{(DATA_W-IMM_W){1'b0}}, bus.in_imm}
                 : {{(DATA_W-IMM_W){bus.in_imm[IMM_W-1]}}, bus.in_imm};

  // Next state, stall request and what the output bank loads this edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    bump    = 1'b0;
    stall   = 1'b0;
    if (flush) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end else if (state_q == ST_STALL) begin
      stall = 1'b1;
      bump  = 1'b1;
      if (cnt_q <= 4'd1) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end else if (hazard) begin
      stall = 1'b1;
      bump  = 1'b1;
      if (STALL_CYC > 1) begin
        state_d = ST_STALL;
        cnt_d   = 4'(STALL_CYC - 1);
      end
    end else if (bus.in_valid) begin
      take = 1'b1;
    end
  end

  // Stall FSM state and remaining-bubble counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else if (clkEnable) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output register bank: latch the decoded instruction or a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_W'(BUBBLE_CTRL);
      rega_q  <= '0;
      regb_q  <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      pc_q    <= '0;
    end else if (clkEnable) begin
      if (take) begin
        valid_q <= 1'b1;
        ctrl_q  <= bus.in_ctrl;
        rega_q  <= bus.in_rega;
        regb_q  <= bus.in_regb;
        imm_q   <= imm_ext;
        rs_q    <= bus.in_rs;
        rt_q    <= bus.in_rt;
        rd_q    <= bus.in_rd;
        pc_q    <= bus.in_pc;
      end else begin
        valid_q <= 1'b0;
        ctrl_q  <= CTRL_W'(BUBBLE_CTRL);
        rega_q  <= '0;
        regb_q  <= '0;
        imm_q   <= '0;
        rs_q    <= '0;
        rt_q    <= '0;
        rd_q    <= '0;
        pc_q    <= '0;
      end
    end
  end

  // Saturating count of bubbles inserted for load-use hazards.
  always_ff @(posedge clk) begin
    if (reset) begin
      bcnt_q <= '0;
    end else if (clkEnable && bump && (bcnt_q != BCNT_MAX)) begin
      bcnt_q <= bcnt_q + 16'd1;
    end
  end

  assign bus.stall_if     = stall;
  assign bus.out_valid    = valid_q;
  assign bus.out_ctrl     = ctrl_q;
  assign bus.out_rega     = rega_q;
  assign bus.out_regb     = regb_q;
  assign bus.out_imm      = imm_q;
  assign bus.out_rs       = rs_q;
  assign bus.out_rt       = rt_q;
  assign bus.out_rd       = rd_q;
  assign bus.out_pc       = pc_q;
  assign bus.bubble_count = bcnt_q;
  assign fsm_state        = state_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: two instances (1 and 3 bubbles per hazard),
// directed scenarios followed by random traffic, all checked against a
// behavioural model of the register's externally visible rules.
module tb_id_ex_stage_reg;
  import pipe_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [8:0]  ctrl;
    logic [31:0] rega;
    logic [31:0] regb;
    logic [15:0] imm;
    logic        zext;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [9:0]  pc;
  } dec_t;

  typedef struct packed {
    logic        valid;
    logic [8:0]  ctrl;
    logic [31:0] rega;
    logic [31:0] regb;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [9:0]  pc;
  } out_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic   rst_d[2];
  logic   en_d[2];
  logic   flush_d[2];
  dec_t   dec[2];
  out_t   obs[2];
  logic   stall_obs[2];
  logic [15:0] bcnt_obs[2];
  state_t state_obs[2];
  logic   last_stall[2];

  id_ex_stage_reg_if if0 ();
  id_ex_stage_reg_if if1 ();

  id_ex_stage_reg #(.STALL_CYC(1)) dut0 (
    .clk(clk), .reset(rst_d[0]), .clkEnable(en_d[0]), .flush(flush_d[0]),
    .bus(if0), .fsm_state(state_obs[0])
  );
  id_ex_stage_reg #(.STALL_CYC(3)) dut1 (
    .clk(clk), .reset(rst_d[1]), .clkEnable(en_d[1]), .flush(flush_d[1]),
    .bus(if1), .fsm_state(state_obs[1])
  );

  assign if0.in_valid = dec[0].valid;  assign if1.in_valid = dec[1].valid;
  assign if0.in_ctrl  = dec[0].ctrl;   assign if1.in_ctrl  = dec[1].ctrl;
  assign if0.in_rega  = dec[0].rega;   assign if1.in_rega  = dec[1].rega;
  assign if0.in_regb  = dec[0].regb;   assign if1.in_regb  = dec[1].regb;
  assign if0.in_imm   = dec[0].imm;    assign if1.in_imm   = dec[1].imm;
  assign if0.in_imm_zext = dec[0].zext; assign if1.in_imm_zext = dec[1].zext;
  assign if0.in_rs    = dec[0].rs;     assign if1.in_rs    = dec[1].rs;
  assign if0.in_rt    = dec[0].rt;     assign if1.in_rt    = dec[1].rt;
  assign if0.in_rd    = dec[0].rd;     assign if1.in_rd    = dec[1].rd;
  assign if0.in_pc    = dec[0].pc;     assign if1.in_pc    = dec[1].pc;

  assign obs[0] = {if0.out_valid, if0.out_ctrl, if0.out_rega, if0.out_regb, if0.out_imm,
                   if0.out_rs, if0.out_rt, if0.out_rd, if0.out_pc};
  assign obs[1] = {if1.out_valid, if1.out_ctrl, if1.out_rega, if1.out_regb, if1.out_imm,
                   if1.out_rs, if1.out_rt, if1.out_rd, if1.out_pc};
  assign stall_obs[0] = if0.stall_if;      assign stall_obs[1] = if1.stall_if;
  assign bcnt_obs[0]  = if0.bubble_count;  assign bcnt_obs[1]  = if1.bubble_count;

  // ---------------- scoreboard / model ----------------
  int   n_checks = 0;
  int   n_errors = 0;
  out_t mdl[2];
  int   bcnt_m[2];
  int   rem[2];     // bubbles still owed after the current one

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic int stall_cycles(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic model_hazard(int i);
    return mdl[i].valid && mdl[i].ctrl[3] && (mdl[i].rt != 0) && dec[i].valid
        && ((mdl[i].rt == dec[i].rs) || (mdl[i].rt == dec[i].rt));
  endfunction

  function automatic logic model_stall(int i);
    return !flush_d[i] && ((rem[i] > 0) || model_hazard(i));
  endfunction

  function automatic out_t expand(dec_t d);
    out_t o;
    o.valid = 1'b1;
    o.ctrl  = d.ctrl;
    o.rega  = d.rega;
    o.regb  = d.regb;
    if (!d.zext && d.imm >= 16'h8000) o.imm = 32'(d.imm) + 32'hFFFF0000;
    else                              o.imm = 32'(d.imm);
    o.rs = d.rs;
    o.rt = d.rt;
    o.rd = d.rd;
    o.pc = d.pc;
    return o;
  endfunction

  task automatic bump(int i);
    if (bcnt_m[i] < 65535) bcnt_m[i]++;
  endtask

  task automatic model_step(int i);
    if (rst_d[i]) begin
      mdl[i] = '0; bcnt_m[i] = 0; rem[i] = 0;
    end else if (en_d[i]) begin
      if (flush_d[i]) begin
        mdl[i] = '0; rem[i] = 0;
      end else if (rem[i] > 0) begin
        mdl[i] = '0; rem[i]--; bump(i);
      end else if (model_hazard(i)) begin
        mdl[i] = '0; rem[i] = stall_cycles(i) - 1; bump(i);
      end else if (dec[i].valid) begin
        mdl[i] = expand(dec[i]);
      end else begin
        mdl[i] = '0;
      end
    end
  endtask

  task automatic chk_out(int i);
    check($sformatf("valid%0d", i), 64'(obs[i].valid), 64'(mdl[i].valid));
    check($sformatf("ctrl%0d", i),  64'(obs[i].ctrl),  64'(mdl[i].ctrl));
    check($sformatf("rega%0d", i),  64'(obs[i].rega),  64'(mdl[i].rega));
    check($sformatf("regb%0d", i),  64'(obs[i].regb),  64'(mdl[i].regb));
    check($sformatf("imm%0d", i),   64'(obs[i].imm),   64'(mdl[i].imm));
    check($sformatf("regs%0d", i),  64'({obs[i].rs, obs[i].rt, obs[i].rd}),
                                    64'({mdl[i].rs, mdl[i].rt, mdl[i].rd}));
    check($sformatf("pc%0d", i),    64'(obs[i].pc),    64'(mdl[i].pc));
    check($sformatf("bcnt%0d", i),  64'(bcnt_obs[i]),  64'(bcnt_m[i]));
  endtask

  // One clock: check combinational stall, advance model, check registers.
  task automatic cycle();
    #1;
    for (int i = 0; i < 2; i++) begin
      last_stall[i] = stall_obs[i];
      check($sformatf("stall%0d", i), 64'(stall_obs[i]), 64'(model_stall(i)));
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i);
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk_out(i);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle(int i);
    dec[i] = '0;
  endtask

  task automatic drive_load(int i, logic [4:0] rt);
    dec[i] = '0;
    dec[i].valid = 1'b1;
    dec[i].ctrl  = 9'h00B;  // MemRead | MemToReg | RegWrite
    dec[i].rt    = rt;
    dec[i].rega  = $urandom();
    dec[i].imm   = 16'(($urandom_range(0, 255)));
  endtask

  task automatic drive_user(int i, logic [4:0] rs, logic [4:0] rt, logic [9:0] pc);
    dec[i] = '0;
    dec[i].valid = 1'b1;
    dec[i].ctrl  = 9'h0C1;
    dec[i].rs    = rs;
    dec[i].rt    = rt;
    dec[i].rd    = 5'd9;
    dec[i].pc    = pc;
    dec[i].rega  = $urandom();
    dec[i].regb  = $urandom();
  endtask

  // Load followed by a dependent instruction held while stall_if is high.
  task automatic load_use(int i, int n_exp, logic [4:0] r, logic [9:0] pc);
    int n_stall;
    int want_cnt;
    drive_idle(i);
    cycle();
    drive_load(i, r);
    cycle();
    want_cnt = bcnt_m[i] + n_exp;
    if (want_cnt > 65535) want_cnt = 65535;
    drive_user(i, r, 5'd2, pc);
    n_stall = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (!last_stall[i]) break;
      n_stall++;
    end
    check($sformatf("lu_stalls%0d", i), 64'(n_stall), 64'(n_exp));
    check($sformatf("lu_valid%0d", i),  64'(obs[i].valid), 64'd1);
    check($sformatf("lu_pc%0d", i),     64'(obs[i].pc), 64'(pc));
    check($sformatf("lu_bcnt%0d", i),   64'(bcnt_obs[i]), 64'(want_cnt));
    drive_idle(i);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_d[i] = 1'b1; en_d[i] = 1'b1; flush_d[i] = 1'b0;
      dec[i] = '0; mdl[i] = '0; bcnt_m[i] = 0; rem[i] = 0; last_stall[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk_out(i);
    rst_d[0] = 1'b0; rst_d[1] = 1'b0;

    // Immediate extension, sign then zero.
    drive_user(0, 5'd1, 5'd2, 10'h011);
    dec[0].rega = 32'h1234; dec[0].imm = 16'h8000; dec[0].zext = 1'b0;
    cycle();
    check("sext_rega", 64'(obs[0].rega), 64'h1234);
    check("sext_imm",  64'(obs[0].imm),  64'hFFFF8000);
    dec[0].zext = 1'b1;
    cycle();
    check("zext_imm",  64'(obs[0].imm),  64'h00008000);

    // Reset while the register holds a real instruction.
    rst_d[0] = 1'b1; rst_d[1] = 1'b1;
    cycle();
    check("rst_valid", 64'(obs[0].valid), 64'd0);
    check("rst_pc",    64'(obs[0].pc),    64'd0);
    rst_d[0] = 1'b0; rst_d[1] = 1'b0;

    // Load-use on both widths of stall.
    load_use(0, 1, 5'd5, 10'h020);
    load_use(1, 3, 5'd5, 10'h030);

    // Flush in the middle of a stall.
    drive_idle(1); cycle();
    drive_load(1, 5'd7); cycle();
    drive_user(1, 5'd7, 5'd3, 10'h040); cycle();
    check("fl_pre_state", 64'(state_obs[1]), 64'(ST_STALL));
    flush_d[1] = 1'b1;
    cycle();
    flush_d[1] = 1'b0;
    check("fl_state", 64'(state_obs[1]), 64'(ST_RUN));
    check("fl_stall", 64'(last_stall[1]), 64'd0);
    cycle();
    check("fl_reload", 64'(obs[1].pc), 64'h040);
    drive_idle(1);

    // Freeze mid-stall, dependency through rt.
    drive_idle(1); cycle();
    drive_load(1, 5'd6); cycle();
    drive_user(1, 5'd4, 5'd6, 10'h050); cycle();
    en_d[1] = 1'b0;
    repeat (4) cycle();
    check("frz_stall", 64'(last_stall[1]), 64'd1);
    check("frz_state", 64'(state_obs[1]), 64'(ST_STALL));
    en_d[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (!last_stall[1]) break;
    end
    check("frz_done", 64'(obs[1].pc), 64'h050);
    drive_idle(1);

    // Saturation of the bubble counter.
    force dut1.bcnt_q = 16'hFFFE;
    #1;
    release dut1.bcnt_q;
    bcnt_m[1] = 65534;
    load_use(1, 3, 5'd8, 10'h060);
    check("sat_cnt", 64'(bcnt_obs[1]), 64'hFFFF);

    // Random traffic with small register space so hazards are frequent.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++) begin
        rst_d[i]   = ($urandom_range(0, 63) == 0);
        en_d[i]    = ($urandom_range(0, 9) != 0);
        flush_d[i] = ($urandom_range(0, 15) == 0);
        dec[i].valid = ($urandom_range(0, 4) != 0);
        dec[i].ctrl  = 9'($urandom());
        dec[i].ctrl[3] = $urandom_range(0, 1) == 1;
        dec[i].rega  = $urandom();
        dec[i].regb  = $urandom();
        dec[i].imm   = 16'($urandom());
        dec[i].zext  = $urandom_range(0, 1) == 1;
        dec[i].rs    = 5'($urandom_range(0, 3));
        dec[i].rt    = 5'($urandom_range(0, 3));
        dec[i].rd    = 5'($urandom_range(0, 31));
        dec[i].pc    = 10'($urandom());
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
